reg_to_apb: RTL and testbench
=============================

Name: reg_to_apb

Overview:
- Bridge from a REG_BUS-style register master to an APB3 completer. It is the reverse of the APB-to-register converter in the peripheral subsystem.
- Lets register-bus initiators reach existing APB peripherals (gpio, adv timer, soc control) without an AXI path. Examples of such initiators: padframe config masters, debug/boot sequencers.
- Handles one outstanding transfer at a time. Runs an APB SETUP/ACCESS state machine with wait states, error mapping, and a registered response.

Parameters:
- ADDR_WIDTH, 32, width of reg and APB address
- DATA_WIDTH, 32, width of data; must be a multiple of 8
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort (used only with REG2APB_TIMEOUT_EN); range 1..255

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- reg_addr_i  in  ADDR_WIDTH  request address
- reg_write_i  in  1  1 = write, 0 = read
- reg_wdata_i  in  DATA_WIDTH  write data
- reg_wstrb_i  in  DATA_WIDTH/8  byte strobes
- reg_valid_i  in  1  request valid; held stable until reg_ready_o
- reg_rdata_o  out  DATA_WIDTH  read data, valid with reg_ready_o
- reg_error_o  out  1  error, valid with reg_ready_o
- reg_ready_o  out  1  one-cycle completion pulse
- paddr_o  out  ADDR_WIDTH  APB address
- pwdata_o  out  DATA_WIDTH  APB write data
- pwrite_o  out  1  APB direction
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- prdata_i  in  DATA_WIDTH  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB slave error
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- One clock (clk_i); reset rst_i is synchronous, active-high.
- Reset values: all outputs 0. State is IDLE; captured address, data, direction and the timeout counter are all 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE, on reg_valid_i=1:
  - Capture addr, wdata and write into registers.
  - If write and reg_wstrb_i is not all-ones: go to RESP with error=1, rdata=0, and issue no APB cycle (partial writes are unsupported).
  - Otherwise go to SETUP.
  - Reads ignore wstrb.
- SETUP (exactly one cycle): psel_o=1, penable_o=0, paddr_o/pwdata_o/pwrite_o driven from the captured registers. Go to ACCESS.
- ACCESS: psel_o=1, penable_o=1, and address/data/direction held unchanged.
  - If pready_i=0: stay in ACCESS.
  - If pready_i=1: register prdata_i (reads only) and pslverr_i, then go to RESP.
- RESP (exactly one cycle): reg_ready_o=1, psel_o=0, penable_o=0, then return to IDLE.
  - reg_error_o = captured pslverr (or the strobe/timeout error).
  - reg_rdata_o = captured prdata for an error-free read, otherwise 0.
- reg_rdata_o and reg_error_o read 0 whenever reg_ready_o=0.
- paddr_o and pwdata_o hold their last value in IDLE. pwdata_o is driven on reads too; its value is don't-care to the completer.
- Latency: with pready_i high on the first ACCESS cycle, request valid at cycle 0 gives reg_ready_o at cycle 3. Each wait state adds one cycle.
- RESP never samples reg_valid_i. A request still held in that cycle is a master protocol violation. The next request is accepted in IDLE, giving a minimum of 4 cycles per transfer.
- The address passes through unmodified; there is no alignment check.
- Reset mid-transfer: state returns to IDLE and psel_o/penable_o are 0 from the next cycle. No reg_ready_o is issued for the aborted request.

Optional Feature:
- Macro: REG2APB_TIMEOUT_EN.
- With the macro:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with pready_i=0.
  - If the counter equals TIMEOUT_CYCLES-1 and pready_i=0: leave ACCESS, drop psel_o/penable_o, and go to RESP with error=1, rdata=0.
  - pready_i=1 on that same cycle wins: normal completion.
- Without the macro: no counter is present, and ACCESS waits indefinitely for pready_i.

Test Plan:
- Read 0x1A10_1004, pready_i=1 at first ACCESS, prdata_i=0xDEADBEEF -> psel_o=1/penable_o=0 at cycle 1; penable_o=1 at cycle 2; reg_ready_o at cycle 3 with rdata 0xDEADBEEF, error 0.
- Write 0x12345678 to 0x1A10_2000, wstrb 0xF, 3 wait states -> paddr_o/pwdata_o stable across cycles 1-5; penable_o high for cycles 2-5; reg_ready_o at cycle 6, error 0, rdata 0.
- Read with pslverr_i=1 and prdata_i=0xFFFF_FFFF -> reg_ready_o at cycle 3, error 1, rdata 0.
- Write with wstrb 0x3 -> psel_o never asserts; reg_ready_o at cycle 1, error 1.
- rst_i high for one cycle during ACCESS -> psel_o/penable_o 0 the next cycle, busy_o 0, no reg_ready_o. A subsequent read completes normally in 4 cycles.
- pready_i held 0:
  - Macro on, TIMEOUT_CYCLES=16 -> ACCESS occupies cycles 2-17, reg_ready_o at cycle 18 with error 1.
  - Macro off -> psel_o/penable_o still high after 1000 cycles and no reg_ready_o. pready_i then rises -> normal completion one cycle later.

Source files
------------

// File: rtl/reg_to_apb.sv
// REG_BUS-style register master to APB3 completer bridge, one transfer in flight.
// Optional build macro REG2APB_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYCLES cycles.
module reg_to_apb #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   reg_addr_i,
  input  logic                    reg_write_i,
  input  logic [DATA_WIDTH-1:0]   reg_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] reg_wstrb_i,
  input  logic                    reg_valid_i,
  output logic [DATA_WIDTH-1:0]   reg_rdata_o,
  output logic                    reg_error_o,
  output logic                    reg_ready_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic                    pwrite_o,
  output logic                    psel_o,
  output logic                    penable_o,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pready_i,
  input  logic                    pslverr_i,
  output logic                    busy_o
);

  // Handshake: the master holds reg_valid_i and its payload stable until accepted in IDLE;
  // reg_ready_o is a single-cycle pulse carrying reg_rdata_o/reg_error_o, zero otherwise.
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;
  logic                    strb_err;
  logic                    timeout_hit;

  assign strb_err = reg_write_i && (reg_wstrb_i != {STRB_WIDTH{1'b1}});

`ifdef REG2APB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt_q;

  assign timeout_hit = (state_q == ACCESS) && !pready_i && (tmo_cnt_q == TIMEOUT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= 8'd0;
    end else if (state_q == SETUP) begin
      tmo_cnt_q <= 8'd0;
    end else if (state_q == ACCESS && !pready_i) begin
      tmo_cnt_q <= tmo_cnt_q + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (reg_valid_i) begin
          state_d = strb_err ? RESP : SETUP;
        end
      end
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (pready_i || timeout_hit) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture and response registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (reg_valid_i) begin
            addr_q  <= reg_addr_i;
            wdata_q <= reg_wdata_i;
            write_q <= reg_write_i;
            rdata_q <= '0;
            err_q   <= strb_err;
          end
        end
        ACCESS: begin
          if (pready_i) begin
            err_q   <= pslverr_i;
            rdata_q <= (!write_q && !pslverr_i) ? prdata_i : '0;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    psel_o      = (state_q == SETUP) || (state_q == ACCESS);
    penable_o   = (state_q == ACCESS);
    reg_ready_o = (state_q == RESP);
    busy_o      = (state_q != IDLE);
    paddr_o     = addr_q;
    pwdata_o    = wdata_q;
    pwrite_o    = write_q;
    reg_rdata_o = '0;
    reg_error_o = 1'b0;
    if (state_q == RESP) begin
      reg_rdata_o = rdata_q;
      reg_error_o = err_q;
    end
  end

endmodule

// File: tb/tb_reg_to_apb.sv
// Self-checking bench for reg_to_apb: directed plan cases plus randomized transfers
// against a transaction-level model; define REG2APB_TIMEOUT_EN to match the DUT build.
module tb_reg_to_apb;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] reg_addr_i;
  logic          reg_write_i;
  logic [DW-1:0] reg_wdata_i;
  logic [SW-1:0] reg_wstrb_i;
  logic          reg_valid_i;
  logic [DW-1:0] reg_rdata_o;
  logic          reg_error_o;
  logic          reg_ready_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o;
  logic          pwrite_o;
  logic          psel_o;
  logic          penable_o;
  logic [DW-1:0] prdata_i;
  logic          pready_i;
  logic          pslverr_i;
  logic          busy_o;

  reg_to_apb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .reg_addr_i(reg_addr_i), .reg_write_i(reg_write_i), .reg_wdata_i(reg_wdata_i),
    .reg_wstrb_i(reg_wstrb_i), .reg_valid_i(reg_valid_i),
    .reg_rdata_o(reg_rdata_o), .reg_error_o(reg_error_o), .reg_ready_o(reg_ready_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o),
    .psel_o(psel_o), .penable_o(penable_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .busy_o(busy_o)
  );

  // Clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW:0] exp_q[$];  // {error, rdata} per expected completion

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard: pops on every completion pulse, responses must be zero otherwise
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_ready_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready actual=1 required=0");
        end else begin
          chk("response", {31'd0, reg_error_o, reg_rdata_o}, {31'd0, exp_q.pop_front()});
        end
      end else begin
        chk("resp_zero_when_idle", {31'd0, reg_error_o, reg_rdata_o}, 64'd0);
      end
    end
  end

  // Driver + APB completer for one transfer; the completer inserts `waits` wait states.
  task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                      input logic [SW-1:0] st, input int waits, input logic serr,
                      input logic [DW-1:0] rd);
    int   cyc;
    int   acc;
    int   exp_lat;
    logic strb_err;
    logic to_err;
    logic seen_psel;
    logic done;
    strb_err = wr && (st != {SW{1'b1}});
    to_err   = 1'b0;
`ifdef REG2APB_TIMEOUT_EN
    to_err   = !strb_err && (waits >= TO);
`endif
    exp_lat  = strb_err ? 1 : (to_err ? 2 + TO : 3 + waits);
    if (strb_err || to_err || serr) exp_q.push_back({1'b1, {DW{1'b0}}});
    else if (wr)                    exp_q.push_back({1'b0, {DW{1'b0}}});
    else                            exp_q.push_back({1'b0, rd});

    reg_addr_i  = addr;
    reg_write_i = wr;
    reg_wdata_i = wd;
    reg_wstrb_i = st;
    reg_valid_i = 1'b1;
    prdata_i    = rd;
    pslverr_i   = serr;
    pready_i    = 1'b0;
    cyc = 0; acc = 0; seen_psel = 1'b0; done = 1'b0;
    while (!done && cyc < 3000) begin
      step();
      cyc++;
      reg_valid_i = 1'b0;
      if (psel_o) begin
        seen_psel = 1'b1;
        chk("paddr", paddr_o, addr);
        chk("pwrite", pwrite_o, wr);
        chk("pwdata", pwdata_o, wd);
        chk("penable_phase", penable_o, cyc != 1);
        if (penable_o) begin
          acc++;
          pready_i = (acc == waits + 1);
        end
      end else begin
        pready_i = 1'b0;
      end
      if (reg_ready_o) begin
        done = 1'b1;
        chk("resp_psel_low", {psel_o, penable_o}, 2'b00);
      end
    end
    chk("completed", done, 1'b1);
    chk("latency", cyc, exp_lat);
    chk("apb_issued", seen_psel, !strb_err);
    pready_i = 1'b0;
    step();
    chk("busy_after", busy_o, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] d;
    rst = 1'b1;
    reg_addr_i = '0; reg_write_i = 1'b0; reg_wdata_i = '0; reg_wstrb_i = '0;
    reg_valid_i = 1'b0; prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
    step();
    step();
    chk("reset_outputs", {reg_ready_o, reg_error_o, psel_o, penable_o, pwrite_o, busy_o}, 6'd0);
    chk("reset_paddr", paddr_o, 0);
    chk("reset_pwdata", pwdata_o, 0);
    rst = 1'b0;
    step();

    xfer(32'h1A10_1004, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'hDEADBEEF);
    xfer(32'h1A10_2000, 1'b1, 32'h12345678, 4'hF, 3, 1'b0, 32'hCAFE0000);
    xfer(32'h1A10_3008, 1'b0, 32'h0, 4'hF, 0, 1'b1, 32'hFFFF_FFFF);
    xfer(32'h1A10_400C, 1'b1, 32'hA5A5A5A5, 4'h3, 0, 1'b0, 32'h0);
    xfer(32'h1A10_5001, 1'b0, 32'h0, 4'h0, TO - 1, 1'b0, 32'h0BADF00D);

    // Reset while in ACCESS: no completion, bus idle next cycle
    reg_addr_i = 32'h1A10_6000; reg_write_i = 1'b0; reg_valid_i = 1'b1; pready_i = 1'b0;
    step();
    reg_valid_i = 1'b0;
    step();
    chk("rst_test_in_access", {psel_o, penable_o}, 2'b11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_abort_bus", {psel_o, penable_o, busy_o}, 3'b000);
    for (int i = 0; i < 3; i++) step();
    xfer(32'h1A10_6004, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h600D_0001);

`ifdef REG2APB_TIMEOUT_EN
    xfer(32'h1A10_7000, 1'b0, 32'h0, 4'h0, 100, 1'b0, 32'h1234);
`else
    xfer(32'h1A10_7000, 1'b0, 32'h0, 4'h0, 1000, 1'b0, 32'h7777_1234);
`endif

    for (int n = 0; n < 80; n++) begin
      d = $urandom;
      xfer($urandom, 1'($urandom_range(0, 1)), d,
           ($urandom_range(0, 5) == 0) ? SW'($urandom_range(0, 14)) : {SW{1'b1}},
`ifdef REG2APB_TIMEOUT_EN
           ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 5)),
`else
           int'($urandom_range(0, 5)),
`endif
           1'($urandom_range(0, 3) == 0), $urandom);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
    end

    step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
